// File: rtl/instr_issue_if.sv
// Request/response bundle between a stimulus source and instr_issue_encoder.
// The master drives requests and consumes responses; the slave is the encoder.
interface instr_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_class;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [11:0] req_imm;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_bt;
  logic [31:0] rsp_tag;
  logic        err_illegal;

  modport master (
    output req_valid, req_class, req_funct3, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready, rsp_valid, rsp_result, rsp_bt, rsp_tag, err_illegal
  );

  modport slave (
    input  req_valid, req_class, req_funct3, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready, rsp_valid, rsp_result, rsp_bt, rsp_tag, err_illegal
  );
endinterface

// File: rtl/instr_issue_encoder.sv
// Encodes abstract R/I/B requests into RISC-V words, queues them, holds each on
// instr_out for a fixed window and returns the core's result sampled in that window.
module instr_issue_encoder #(
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_CYCLES  = 5,
  parameter int SAMPLE_CYCLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  instr_issue_if.slave bus,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic [31:0] alu_result,
  input  logic        bt
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [1:0]  CLS_R    = 2'b00;
  localparam logic [1:0]  CLS_I    = 2'b01;
  localparam logic [1:0]  CLS_B    = 2'b10;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [0:0]        state_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [31:0]       instr_out_reg;
  logic              instr_valid_reg;
  logic              rsp_valid_reg;
  logic [31:0]       rsp_result_reg;
  logic              rsp_bt_reg;
  logic [31:0]       rsp_tag_reg;
  logic              err_illegal_reg;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              last_hold;
  logic              sample_now;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b0;
    case (bus.req_class)
      CLS_R: begin
        enc_word  = {7'b0, bus.req_rs2, bus.req_rs1, bus.req_funct3, bus.req_rd, 7'b0110011};
        enc_legal = (bus.req_funct3 <= 3'd4);
      end
      CLS_I: begin
        enc_word  = {bus.req_imm, bus.req_rs1, bus.req_funct3, bus.req_rd, 7'b0010011};
        enc_legal = (bus.req_funct3 <= 3'd1);
      end
      CLS_B: begin
        // req_imm carries offset bits [12:1], so imm[11] is offset bit 12
        enc_word  = {bus.req_imm[11], bus.req_imm[9:4], bus.req_rs2, bus.req_rs1,
                     bus.req_funct3, bus.req_imm[3:0], bus.req_imm[10], 7'b1100011};
        enc_legal = (bus.req_funct3 <= 3'd3);
      end
      default: begin
        enc_word  = 32'h0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // Ready looks only at the registered count: no same-edge pop bypass.
  assign bus.req_ready = (count_reg != CNT_W'(FIFO_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = accept && enc_legal;
  assign fifo_empty    = (count_reg == '0);
  assign last_hold     = (state_reg == HOLD) && (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1));
  assign sample_now    = (state_reg == HOLD) && (hold_cnt_reg == HOLD_W'(SAMPLE_CYCLE));
  assign pop           = !fifo_empty && ((state_reg == IDLE) || last_hold);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      instr_out_reg   <= NOP_WORD;
      instr_valid_reg <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_result_reg  <= 32'h0;
      rsp_bt_reg      <= 1'b0;
      rsp_tag_reg     <= 32'h0;
      err_illegal_reg <= 1'b0;
    end else begin
      err_illegal_reg <= accept && !enc_legal;
      rsp_valid_reg   <= 1'b0;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase

      if (sample_now) begin
        rsp_valid_reg  <= 1'b1;
        rsp_result_reg <= alu_result;
        rsp_bt_reg     <= bt;
        rsp_tag_reg    <= instr_out_reg;
      end

      // Popping at the last hold cycle chains the next word with no NOP gap.
      if (pop) begin
        instr_out_reg   <= fifo_mem[rd_ptr_reg];
        instr_valid_reg <= 1'b1;
        hold_cnt_reg    <= '0;
        state_reg       <= HOLD;
      end else if (last_hold) begin
        instr_out_reg   <= NOP_WORD;
        instr_valid_reg <= 1'b0;
        hold_cnt_reg    <= '0;
        state_reg       <= IDLE;
      end else if (state_reg == HOLD) begin
        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
      end
    end
  end

  assign instr_out       = instr_out_reg;
  assign instr_valid     = instr_valid_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_result  = rsp_result_reg;
  assign bus.rsp_bt      = rsp_bt_reg;
  assign bus.rsp_tag     = rsp_tag_reg;
  assign bus.err_illegal = err_illegal_reg;
endmodule
